// File: rtl/dm_arb_pkg.sv
// dm_arb_pkg: shared types, default widths and helpers for the data-memory port arbiter
// Contents: dm_arb_state_t (last-owner FSM state), DM_AW/DM_DW defaults,
//   cnt_w(limit) giving the width needed to hold 0..limit.
package dm_arb_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_A, ST_B, ST_BLOCK} dm_arb_state_t;

    localparam int DM_AW = 5;
    localparam int DM_DW = 32;

    function automatic int cnt_w(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/dm_arb_starve_ctr.sv
// dm_arb_starve_ctr: saturating count of consecutive cycles port A waits without a grant
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   a_req, a_gnt    port A request and grant for the current cycle
//   cnt             current count, saturates at LIMIT
//   at_limit        cnt has reached LIMIT
module dm_arb_starve_ctr
    import dm_arb_pkg::*;
#(
    parameter int LIMIT = 8,
    parameter int W     = cnt_w(LIMIT)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         a_req,
    input  logic         a_gnt,
    output logic [W-1:0] cnt,
    output logic         at_limit
);

    assign at_limit = cnt == W'(LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (!a_req || a_gnt)
            cnt <= '0;
        else if (!at_limit)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: shares the single-port data memory between the CPU (A) and debug/DMA loader (B)
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   a_req/a_we/a_addr/a_wdata       port A request (held until a_gnt)
//   a_gnt, a_rvalid, a_rdata        A grant (combinational), 1-cycle read response
//   b_req/b_we/b_addr/b_wdata, b_gnt, b_rvalid, b_rdata   same for port B
//   b_lock                          B asks to keep ownership across successive grants
//   b_lock_lost                     1-cycle pulse after the starvation guard broke a B lock
//   dm_addr, dm_wd, dm_we           drive to the memory
//   dm_rd                           combinational read data from the memory
// Build option: DM_ARB_RR_EN makes simultaneous requests alternate instead of favouring A.
module dm_port_arbiter
    import dm_arb_pkg::*;
#(
    parameter int AW           = DM_AW,
    parameter int DW           = DM_DW,
    parameter int STARVE_LIMIT = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,
    input  logic          b_lock,
    output logic          b_lock_lost,
    output logic [AW-1:0] dm_addr,
    output logic [DW-1:0] dm_wd,
    output logic          dm_we,
    input  logic [DW-1:0] dm_rd
);

    localparam int CW = cnt_w(STARVE_LIMIT);

    dm_arb_state_t state, state_nxt;
    logic [CW-1:0] starve_cnt;
    logic          starve_hit;
    logic          lock_hold;
    logic          lock_break;
    logic          b_wins_both;

    dm_arb_starve_ctr #(.LIMIT(STARVE_LIMIT), .W(CW)) u_starve (
        .clk      (clk),
        .rst_n    (rst_n),
        .a_req    (a_req),
        .a_gnt    (a_gnt),
        .cnt      (starve_cnt),
        .at_limit (starve_hit)
    );

    always_comb begin
        lock_hold  = state == ST_BLOCK && b_req && b_lock && !starve_hit;
        lock_break = state == ST_BLOCK && starve_hit && a_req;
`ifdef DM_ARB_RR_EN
        b_wins_both = state == ST_A;
`else
        b_wins_both = 1'b0;
`endif
        // lock_hold and lock_break are exclusive via starve_hit; outside them
        // the tie between two requesters is settled by b_wins_both
        a_gnt     = !lock_hold && (lock_break || (a_req && !(b_req && b_wins_both)));
        b_gnt     = !lock_break && (lock_hold || (b_req && !(a_req && !b_wins_both)));
        state_nxt = a_gnt ? ST_A : b_gnt ? (b_lock ? ST_BLOCK : ST_B) : ST_IDLE;
        dm_we     = a_gnt ? a_we : b_gnt && b_we;
        dm_addr   = a_gnt ? a_addr : b_gnt ? b_addr : '0;
        dm_wd     = a_gnt ? a_wdata : b_gnt ? b_wdata : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            a_rvalid    <= 1'b0;
            b_rvalid    <= 1'b0;
            a_rdata     <= '0;
            b_rdata     <= '0;
            b_lock_lost <= 1'b0;
        end else begin
            state       <= state_nxt;
            a_rvalid    <= a_gnt && !a_we;
            b_rvalid    <= b_gnt && !b_we;
            b_lock_lost <= lock_break;
            if (a_gnt && !a_we)
                a_rdata <= dm_rd;
            if (b_gnt && !b_we)
                b_rdata <= dm_rd;
        end
    end

endmodule
